// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  // Indexed by {row, col}
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1,    4'h2, 4'h3,   KEY_ADD,
    4'h4,    4'h5, 4'h6,   KEY_SUB,
    4'h7,    4'h8, 4'h9,   KEY_MUL,
    KEY_CLR, 4'h0, KEY_EQ, KEY_DIV
  };

  // Lowest-index row that is pulled low; only meaningful when some row is low.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync2 #(
  parameter int                DATA_W  = 4,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;
  logic [DATA_W-1:0] sync_p1;

  // Two back-to-back flops give metastability time to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, row debounce, one strobe per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_en,
  output logic       equal,
  output logic [3:0] in
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  logic [3:0]    rows_s;
  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    rows_lat_q, rows_lat_d;
  logic [3:0]    in_q, in_d;
  logic          key_en_q, key_en_d;
  logic          equal_q, equal_d;
  logic [3:0]    col_out_q;
  logic [3:0]    code;

  sync2 #(.DATA_W(4), .RST_VAL(4'hF)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_in),
    .q     (rows_s)
  );

  assign code = KEYMAP[{row_q, col_q}];

  // Next-state, counters and strobe decode.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    scnt_d     = scnt_q;
    dcnt_d     = dcnt_q;
    row_d      = row_q;
    rows_lat_d = rows_lat_q;
    in_d       = in_q;
    key_en_d   = 1'b0;
    equal_d    = 1'b0;
    case (state_q)
      SCAN: begin
        if (scnt_q == SCAN_LAST) begin
          scnt_d = '0;
          if (rows_s != 4'hF) begin
            row_d      = lowest_row(rows_s);
            rows_lat_d = rows_s;
            dcnt_d     = '0;
            state_d    = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (rows_s != rows_lat_q) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          scnt_d  = '0;
        end else if (dcnt_q == DB_LAST) begin
          in_d    = code;
          state_d = HOLD;
          if (code == KEY_EQ) equal_d  = 1'b1;
          else                key_en_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      HOLD: begin
        if (rows_s == 4'hF) begin
          dcnt_d  = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // A bounce restarts the release count; it never counts as a new press.
        if (rows_s != 4'hF) begin
          dcnt_d = '0;
        end else if (dcnt_q == DB_LAST) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          scnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d = SCAN;
        col_d   = 2'd0;
        scnt_d  = '0;
        dcnt_d  = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      col_q      <= 2'd0;
      scnt_q     <= '0;
      dcnt_q     <= '0;
      row_q      <= 2'd0;
      rows_lat_q <= 4'hF;
      in_q       <= 4'h0;
      key_en_q   <= 1'b0;
      equal_q    <= 1'b0;
      col_out_q  <= 4'b1110;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      scnt_q     <= scnt_d;
      dcnt_q     <= dcnt_d;
      row_q      <= row_d;
      rows_lat_q <= rows_lat_d;
      in_q       <= in_d;
      key_en_q   <= key_en_d;
      equal_q    <= equal_d;
      col_out_q  <= ~(4'b0001 << col_d);
    end
  end

  assign col_out = col_out_q;
  assign key_en  = key_en_q;
  assign equal   = equal_q;
  assign in      = in_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_en;
  logic       equal;
  logic [3:0] in;
  logic [15:0] pressed = 16'h0;   // bit col*4+row set = switch closed

  int checks = 0;
  int errors = 0;
  int ken_cnt = 0;
  int eq_cnt = 0;
  int both_cnt = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .row_in  (row_in),
    .col_out (col_out),
    .key_en  (key_en),
    .equal   (equal),
    .in      (in)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed switch pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col_out[c]) row_in = row_in & ~pressed[c*4 +: 4];
    end
  end

  // Strobe counters, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (key_en) ken_cnt = ken_cnt + 1;
    if (equal) eq_cnt = eq_cnt + 1;
    if (key_en && equal) both_cnt = both_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] key_mask(input int row, input int col);
    return 16'(1) << (col * 4 + row);
  endfunction

  // Wait until the scanner starts driving column pattern `target` afresh.
  task automatic wait_col(input logic [3:0] target, output bit found);
    logic [3:0] prev;
    found = 1'b0;
    prev = col_out;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col_out == target && prev != target) found = 1'b1;
      prev = col_out;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0;
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col_out: got %b expected 1110", col_out); end
    checks++; if (key_en !== 1'b0) begin errors++; $display("FAIL reset_key_en: got %b expected 0", key_en); end
    checks++; if (equal !== 1'b0) begin errors++; $display("FAIL reset_equal: got %b expected 0", equal); end
    checks++; if (in !== 4'h0) begin errors++; $display("FAIL reset_in: got %h expected 0", in); end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (col_out !== exp) begin errors++; $display("FAIL scan_col_out cycle %0d: got %b expected %b", k, col_out, exp); end
      checks++;
      if ({key_en, equal, in} !== 6'b0) begin
        errors++; $display("FAIL scan_idle_outputs cycle %0d: got key_en=%b equal=%b in=%h expected 0 0 0", k, key_en, equal, in);
      end
    end
  endtask

  task automatic test_key5();
    bit found;
    int k0, e0;
    k0 = ken_cnt; e0 = eq_cnt;
    wait_col(4'b1101, found);
    checks++; if (!found) begin errors++; $display("FAIL key5_find_col1: got timeout expected column 1"); end
    pressed = key_mask(1, 1);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i == 11) begin
        checks++; if (key_en !== 1'b0) begin errors++; $display("FAIL key5_early: got key_en=%b expected 0", key_en); end
      end
      if (i == 12) begin
        checks++; if (key_en !== 1'b1) begin errors++; $display("FAIL key5_latency: got key_en=%b expected 1", key_en); end
        checks++; if (in !== 4'h5) begin errors++; $display("FAIL key5_code: got %h expected 5", in); end
      end
      if (i == 13) begin
        checks++; if (key_en !== 1'b0) begin errors++; $display("FAIL key5_one_cycle: got key_en=%b expected 0", key_en); end
      end
    end
    repeat (87) @(negedge clk);
    pressed = 16'h0;
    repeat (30) @(negedge clk);
    checks++; if (ken_cnt - k0 != 1) begin errors++; $display("FAIL key5_count: got %0d expected 1", ken_cnt - k0); end
    checks++; if (eq_cnt - e0 != 0) begin errors++; $display("FAIL key5_no_equal: got %0d expected 0", eq_cnt - e0); end
    checks++; if (in !== 4'h5) begin errors++; $display("FAIL key5_in_held: got %h expected 5", in); end
  endtask

  task automatic test_bounce();
    bit found;
    int k0, e0;
    k0 = ken_cnt; e0 = eq_cnt;
    wait_col(4'b1110, found);
    checks++; if (!found) begin errors++; $display("FAIL bounce_find_col0: got timeout expected column 0"); end
    pressed = key_mask(0, 0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 5) begin
        checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL bounce_col_held: got %b expected 1110", col_out); end
        pressed = 16'h0;
      end
      if (i == 7) begin
        checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL bounce_col_held2: got %b expected 1110", col_out); end
      end
      if (i == 8) begin
        checks++; if (col_out !== 4'b1101) begin errors++; $display("FAIL bounce_next_col: got %b expected 1101", col_out); end
      end
    end
    repeat (20) @(negedge clk);
    checks++; if (ken_cnt - k0 != 0 || eq_cnt - e0 != 0) begin
      errors++; $display("FAIL bounce_no_strobe: got key_en=%0d equal=%0d expected 0 0", ken_cnt - k0, eq_cnt - e0);
    end
  endtask

  task automatic test_equal();
    int k0, e0;
    k0 = ken_cnt; e0 = eq_cnt;
    pressed = key_mask(3, 2);
    repeat (40) @(negedge clk);
    checks++; if (eq_cnt - e0 != 1) begin errors++; $display("FAIL equal_count: got %0d expected 1", eq_cnt - e0); end
    checks++; if (ken_cnt - k0 != 0) begin errors++; $display("FAIL equal_no_key_en: got %0d expected 0", ken_cnt - k0); end
    checks++; if (in !== 4'hF) begin errors++; $display("FAIL equal_code: got %h expected F", in); end
    pressed = 16'h0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_multi_row_release_bounce();
    int k0, e0;
    k0 = ken_cnt; e0 = eq_cnt;
    pressed = key_mask(0, 3) | key_mask(2, 3);
    repeat (40) @(negedge clk);
    checks++; if (ken_cnt - k0 != 1) begin errors++; $display("FAIL multi_count: got %0d expected 1", ken_cnt - k0); end
    checks++; if (in !== 4'hA) begin errors++; $display("FAIL multi_code: got %h expected A", in); end
    for (int b = 0; b < 3; b++) begin
      pressed = 16'h0;
      repeat (2) @(negedge clk);
      pressed = key_mask(0, 3) | key_mask(2, 3);
      repeat (2) @(negedge clk);
    end
    pressed = 16'h0;
    repeat (30) @(negedge clk);
    checks++; if (ken_cnt - k0 != 1) begin errors++; $display("FAIL release_bounce_count: got %0d expected 1", ken_cnt - k0); end
    checks++; if (eq_cnt - e0 != 0) begin errors++; $display("FAIL release_bounce_equal: got %0d expected 0", eq_cnt - e0); end
    checks++; if (in !== 4'hA) begin errors++; $display("FAIL release_bounce_in: got %h expected A", in); end
  endtask

  task automatic test_reset_mid_debounce();
    bit found;
    int k0, e0;
    wait_col(4'b1101, found);
    checks++; if (!found) begin errors++; $display("FAIL midrst_find_col1: got timeout expected column 1"); end
    pressed = key_mask(2, 1);
    repeat (7) @(negedge clk);
    k0 = ken_cnt; e0 = eq_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL midrst_col_out: got %b expected 1110", col_out); end
    checks++; if (in !== 4'h0) begin errors++; $display("FAIL midrst_in: got %h expected 0", in); end
    checks++; if (key_en !== 1'b0 || equal !== 1'b0) begin
      errors++; $display("FAIL midrst_strobes: got key_en=%b equal=%b expected 0 0", key_en, equal);
    end
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (ken_cnt - k0 != 0 || eq_cnt - e0 != 0) begin
      errors++; $display("FAIL midrst_no_strobe: got key_en=%0d equal=%0d expected 0 0", ken_cnt - k0, eq_cnt - e0);
    end
    k0 = ken_cnt;
    pressed = key_mask(2, 1);
    repeat (50) @(negedge clk);
    checks++; if (ken_cnt - k0 != 1) begin errors++; $display("FAIL midrst_fresh_press: got %0d expected 1", ken_cnt - k0); end
    checks++; if (in !== 4'h8) begin errors++; $display("FAIL midrst_fresh_code: got %h expected 8", in); end
    pressed = 16'h0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL strobes_exclusive: got %0d overlaps expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_key5();
    test_bounce();
    test_equal();
    test_multi_row_release_bounce();
    test_reset_mid_debounce();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- Scans a 4x4 active-low matrix keypad, synchronizes and debounces the rows, and decodes one key per press.
- Produces the calculator's key input stream: a one-cycle `key_en` strobe with a 4-bit key code on `in`, or a one-cycle `equal` strobe for the '=' key.
- Sits between the board keypad pins and the calculator core, which consumes `key_en`/`equal`/`in` directly.

## Interface
Decided: one clock; reset is asynchronous and active-low.

Parameters:
- `SCAN_DIV`, default 1000: clock cycles each column is driven during scanning (minimum 4).
- `DEBOUNCE_CNT`, default 20000: consecutive stable cycles required to accept a press or a release (minimum 2).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `row_in`  in  4  keypad rows; pulled up, low = key closed; asynchronous to `clk`.
- `col_out`  out  4  keypad column drive; exactly one bit low (active), others high.
- `key_en`  out  1  one-cycle strobe; `in` is valid for non-'=' keys.
- `equal`  out  1  one-cycle strobe for the '=' key (code 4'hF).
- `in`  out  4  key code of the last accepted key; held until the next press.

## Operation
- Rows pass through a 2-flop synchronizer; `rows_s` is the synchronized value. All decisions use `rows_s`.
- Column index `col` (0-3) selects the driven column: `col_out = ~(4'b0001 << col)`.
- Keymap, {row,col} to code:
  - row0: 1, 2, 3, A(+).
  - row1: 4, 5, 6, B(-).
  - row2: 7, 8, 9, C(*).
  - row3: E(clear), 0, F(=), D(/).
- Several rows low in one column: the lowest row index wins.
- Keys in other columns are ignored until the current press is released.
- FSM states:
  - SCAN: `col` advances (3 wraps to 0) every `SCAN_DIV` cycles. At the last cycle of a column period, if `rows_s != 4'hF`: latch `row`/`col`, clear `dcnt`, go to DEBOUNCE.
  - DEBOUNCE: column held.
    - If `rows_s` differs from the latched value: go to SCAN, advance to the next column with a fresh period.
    - Else `dcnt++`; at `dcnt == DEBOUNCE_CNT-1`: emit the strobe, load `in`, go to HOLD.
  - HOLD: column held; no output. When `rows_s == 4'hF`: clear `dcnt`, go to RELEASE.
  - RELEASE: column held.
    - Any row low: clear `dcnt` and stay; a bounce is never a new press.
    - `dcnt == DEBOUNCE_CNT-1` with all rows high: go to SCAN, advance `col`.
  - Illegal state: go to SCAN, `col = 0`.
- Strobe selection:
  - Code 4'hF: `equal=1`, `key_en=0`.
  - All other codes: `key_en=1`, `equal=0`.
  - `key_en` and `equal` are never high together.
- Exactly one strobe per accepted press, regardless of hold length.

## Timing
- Reset values:
  - `col_out = 4'b1110`, `key_en = 0`, `equal = 0`, `in = 4'h0`.
  - State SCAN; `col`, scan counter, `dcnt` and synchronizer flops all cleared (synchronizer to 4'hF).
- All outputs are registered. `in` updates in the same cycle the strobe rises and holds afterwards.
- Latency, detection to strobe: DEBOUNCE entry plus `DEBOUNCE_CNT` cycles (strobe registered on the cycle after `dcnt` reaches the terminal value). Worst case from pin: 2 sync + `4*SCAN_DIV` + `DEBOUNCE_CNT` + 1 cycles.
- Reset mid-operation (any state): all outputs return to reset values immediately; no pending strobe survives.
- Counter widths: `$clog2` of the parameter; no overflow because terminal compare precedes wrap.

## Structure
- Package `keypad_pkg`:
  - State enum (SCAN, DEBOUNCE, HOLD, RELEASE).
  - 16-entry `KEYMAP` constant.
  - Code constants `KEY_CLR = 4'hE`, `KEY_EQ = 4'hF`, `KEY_ADD..KEY_DIV = 4'hA..4'hD`.
- One sub-module, `sync2` (2-flop synchronizer, width-parameterized, reset value parameter). Everything else lives in `keypad_scanner`.

## Test plan
Use `SCAN_DIV=4`, `DEBOUNCE_CNT=8`.
1. Reset asserted, then released with `row_in=4'hF` -> `col_out` cycles 1110, 1101, 1011, 0111 every 4 cycles; `key_en`, `equal`, `in` stay 0.
2. Hold row1 low while col1 is driven (key '5') for 100 cycles -> exactly one `key_en` pulse with `in=4'h5`; `in` stays 5 after release.
3. Row0 low for 5 cycles only (bounce shorter than 8) -> no strobe; scanning resumes at the next column.
4. Press row3/col2 -> `equal` pulses once, `key_en` stays 0, `in=4'hF`.
5. Rows 0 and 2 low together in col3 -> `key_en` with `in=4'hA`. Release with 3 bounces of 2 cycles each -> no second strobe.
6. Deassert `rst_n` in the middle of DEBOUNCE for key '8' -> outputs at reset values asynchronously; no strobe after reset release until a fresh full press.
